// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//
// Character queue that sits between a bus peripheral (the writer) and a UART
// transmitter (the reader). It uses a register array with separate write and
// read pointers and an occupancy counter. Every output comes from registered
// state. A character written into an empty queue appears on tx_data one cycle
// later, because there is no fall-through path.
//
// Optional feature (compile-time macro UART_TX_FIFO_OVERFLOW_EN):
//   adds a sticky overflow flag that is set whenever the writer offers a
//   character while the queue is full, and an overflow_clr input that clears
//   the flag. When both happen on the same edge, the set wins.
//
// Parameters
//   DATA_BITS   width of each character (default 8)
//   DEPTH       number of entries, a power of two >= 2 (default 16)
//   LEVEL_BITS  width of the level output (default $clog2(DEPTH)+1)
//
// Ports
//   clk           sole clock, rising edge
//   resetn        asynchronous active-low reset
//   wr_data       character offered by the writer
//   wr_valid      wr_data is offered this cycle
//   wr_ready      queue can accept a character (== !full)
//   tx_data       head-of-queue character
//   tx_valid      tx_data is valid (== !empty)
//   tx_req        transmitter takes tx_data on an edge where tx_valid is high
//   level         number of occupied entries, 0..DEPTH
//   empty         level == 0
//   full          level == DEPTH
//   overflow      (macro only) sticky flag for writes dropped because full
//   overflow_clr  (macro only) clears overflow
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int DEPTH      = 16,
    parameter int LEVEL_BITS = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [DATA_BITS-1:0]  wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [DATA_BITS-1:0]  tx_data,
    output logic                  tx_valid,
    input  logic                  tx_req,
    output logic [LEVEL_BITS-1:0] level,
    output logic                  empty,
`ifdef UART_TX_FIFO_OVERFLOW_EN
    output logic                  full,
    output logic                  overflow,
    input  logic                  overflow_clr
`else
    output logic                  full
`endif
);

    localparam int PTR_BITS = $clog2(DEPTH);

    localparam logic [PTR_BITS-1:0]   PTR_ONE    = PTR_BITS'(1);
    localparam logic [LEVEL_BITS-1:0] LEVEL_ONE  = LEVEL_BITS'(1);
    localparam logic [LEVEL_BITS-1:0] LEVEL_FULL = LEVEL_BITS'(DEPTH);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [DATA_BITS-1:0]  mem [DEPTH];
    logic [PTR_BITS-1:0]   wr_ptr;
    logic [PTR_BITS-1:0]   rd_ptr;
    logic [LEVEL_BITS-1:0] level_q;

    // Handshake qualifiers. Both depend only on registered flags, so a write
    // offered while full is dropped even when a pop frees a slot on the same
    // edge. The freed slot can be written on the next cycle.
    logic push;
    logic pop;

    assign push = wr_valid && wr_ready;
    assign pop  = tx_valid && tx_req;

    // -------------------------------------------------------------------------
    // Outputs (registered state only)
    // -------------------------------------------------------------------------
    assign level    = level_q;
    assign empty    = (level_q == '0);
    assign full     = (level_q == LEVEL_FULL);
    assign wr_ready = !full;
    assign tx_valid = !empty;
    assign tx_data  = mem[rd_ptr];

    // -------------------------------------------------------------------------
    // Storage array
    // -------------------------------------------------------------------------
    // NOTE: the array is deliberately left out of reset. Its contents are
    // never observable while empty (tx_valid low), and a resettable array
    // would cost a reset net on every storage bit.
    always_ff @(posedge clk) begin
        if (push) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block ordering.
            mem[wr_ptr] <= wr_data;
        end
    end

    // -------------------------------------------------------------------------
    // Pointers. DEPTH is a power of two, so natural overflow of the PTR_BITS
    // wide adder gives the wrap from DEPTH-1 back to 0.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
        end else if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr <= '0;
        end else if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // -------------------------------------------------------------------------
    // Occupancy counter. pop is never true when empty, and push is never true
    // when full, so the counter cannot wrap in either direction.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            level_q <= '0;
        end else begin
            case ({push, pop})
                2'b10:   level_q <= level_q + LEVEL_ONE;
                2'b01:   level_q <= level_q - LEVEL_ONE;
                default: level_q <= level_q;
            endcase
        end
    end

`ifdef UART_TX_FIFO_OVERFLOW_EN
    // -------------------------------------------------------------------------
    // Sticky overflow flag. A dropped write sets the flag, and the set takes
    // priority over a clear on the same edge, so a drop is never lost.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overflow <= 1'b0;
        end else if (wr_valid && full) begin
            overflow <= 1'b1;
        end else if (overflow_clr) begin
            overflow <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
//
// Self-checking bench for uart_tx_fifo. The reference model is a queue of
// characters. Each edge pops the head if the transmitter asks for it and the
// queue is non-empty. It then appends the offered character if the queue was
// not full before the edge. The expected outputs follow from the queue size
// and its head.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

    localparam int DATA_BITS  = 8;
    localparam int DEPTH      = 16;
    localparam int LEVEL_BITS = $clog2(DEPTH) + 1;

    logic                  clk;
    logic                  resetn;
    logic [DATA_BITS-1:0]  wr_data;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_BITS-1:0]  tx_data;
    logic                  tx_valid;
    logic                  tx_req;
    logic [LEVEL_BITS-1:0] level;
    logic                  empty;
    logic                  full;
`ifdef UART_TX_FIFO_OVERFLOW_EN
    logic                  overflow;
    logic                  overflow_clr;
    logic                  model_ov;
`endif

    logic [DATA_BITS-1:0] model_q[$];
    int checks = 0;
    int passes = 0;

    uart_tx_fifo #(
        .DATA_BITS (DATA_BITS),
        .DEPTH     (DEPTH),
        .LEVEL_BITS(LEVEL_BITS)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .wr_data     (wr_data),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_req      (tx_req),
        .level       (level),
        .empty       (empty),
`ifdef UART_TX_FIFO_OVERFLOW_EN
        .full        (full),
        .overflow    (overflow),
        .overflow_clr(overflow_clr)
`else
        .full        (full)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    // One clock edge with the given inputs. The model is updated from its
    // pre-edge state, and outputs may be sampled on return (1 time unit
    // after the edge).
    task automatic drive(input logic wv, input logic [DATA_BITS-1:0] wd, input logic tr);
        bit do_push;
        bit do_pop;
        wr_valid = wv;
        wr_data  = wd;
        tx_req   = tr;
        do_push  = wv && (model_q.size() < DEPTH);
        do_pop   = tr && (model_q.size() != 0);
`ifdef UART_TX_FIFO_OVERFLOW_EN
        if (wv && model_q.size() == DEPTH) model_ov = 1'b1;
        else if (overflow_clr)             model_ov = 1'b0;
`endif
        @(posedge clk);
        if (do_pop)  void'(model_q.pop_front());
        if (do_push) model_q.push_back(wd);
        #1;
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        model_q.delete();
`ifdef UART_TX_FIFO_OVERFLOW_EN
        model_ov = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        wr_valid = 1'b0;
        wr_data  = '0;
        tx_req   = 1'b0;
`ifdef UART_TX_FIFO_OVERFLOW_EN
        overflow_clr = 1'b0;
`endif
        resetn = 1'b0;
        model_q.delete();
`ifdef UART_TX_FIFO_OVERFLOW_EN
        model_ov = 1'b0;
`endif
        #3;
        checks++;
        if ({level, empty, full, wr_ready, tx_valid} !== {5'd0, 1'b1, 1'b0, 1'b1, 1'b0})
            $display("FAIL reset_state: got level=%0d empty=%b full=%b wr_ready=%b tx_valid=%b, expected 0 1 0 1 0",
                     level, empty, full, wr_ready, tx_valid);
        else passes++;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    task automatic test_single_push();
        drive(1'b1, 8'h41, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        checks++;
        if ({tx_valid, tx_data, level, empty} !== {1'b1, 8'h41, 5'd1, 1'b0})
            $display("FAIL single_push: got tx_valid=%b tx_data=%h level=%0d empty=%b, expected 1 41 1 0",
                     tx_valid, tx_data, level, empty);
        else passes++;
        drive(1'b0, 8'h00, 1'b1);
        checks++;
        if (empty !== 1'b1 || level !== 5'd0)
            $display("FAIL single_pop: got empty=%b level=%0d, expected 1 0", empty, level);
        else passes++;
        // tx_req while empty must leave the level and the queue untouched.
        drive(1'b0, 8'h00, 1'b1);
        checks++;
        if (level !== 5'd0 || tx_valid !== 1'b0)
            $display("FAIL pop_when_empty: got level=%0d tx_valid=%b, expected 0 0", level, tx_valid);
        else passes++;
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 8'(i), 1'b0);
        checks++;
        if ({full, wr_ready, level} !== {1'b1, 1'b0, 5'd16})
            $display("FAIL fill_flags: got full=%b wr_ready=%b level=%0d, expected 1 0 16", full, wr_ready, level);
        else passes++;
        drive(1'b1, 8'hFF, 1'b0);
        checks++;
        if (level !== 5'd16)
            $display("FAIL drop_17th: got level=%0d, expected 16", level);
        else passes++;
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== 8'(i))
                $display("FAIL drain_order[%0d]: got valid=%b data=%h, expected 1 %h", i, tx_valid, tx_data, 8'(i));
            else passes++;
            drive(1'b0, 8'h00, 1'b1);
        end
        checks++;
        if (empty !== 1'b1 || level !== 5'd0)
            $display("FAIL drain_empty: got empty=%b level=%0d, expected 1 0", empty, level);
        else passes++;
    endtask

    task automatic test_back_to_back();
        logic [DATA_BITS-1:0] d;
        for (int i = 0; i < 8; i++) drive(1'b1, 8'($urandom), 1'b0);
        for (int i = 0; i < 40; i++) begin
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== model_q[0])
                $display("FAIL steady_head[%0d]: got valid=%b data=%h, expected 1 %h", i, tx_valid, tx_data, model_q[0]);
            else passes++;
            d = 8'($urandom);
            drive(1'b1, d, 1'b1);
            checks++;
            if (level !== 5'd8)
                $display("FAIL steady_level[%0d]: got %0d, expected 8", i, level);
            else passes++;
        end
        while (model_q.size() != 0) begin
            checks++;
            if (tx_data !== model_q[0])
                $display("FAIL steady_drain: got %h, expected %h", tx_data, model_q[0]);
            else passes++;
            drive(1'b0, 8'h00, 1'b1);
        end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 8'(8'h80 + i), 1'b0);
        drive(1'b1, 8'hAA, 1'b1);
        checks++;
        if ({level, wr_ready, full} !== {5'd15, 1'b1, 1'b0})
            $display("FAIL full_push_pop: got level=%0d wr_ready=%b full=%b, expected 15 1 0", level, wr_ready, full);
        else passes++;
        for (int i = 1; i < DEPTH; i++) begin
            checks++;
            if (tx_data !== 8'(8'h80 + i))
                $display("FAIL full_push_pop_drain[%0d]: got %h, expected %h", i, tx_data, 8'(8'h80 + i));
            else passes++;
            drive(1'b0, 8'h00, 1'b1);
        end
        checks++;
        if (tx_valid !== 1'b0)
            $display("FAIL full_push_pop_dropped: got tx_valid=%b data=%h, expected empty", tx_valid, tx_data);
        else passes++;
    endtask

`ifdef UART_TX_FIFO_OVERFLOW_EN
    task automatic test_overflow();
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 8'(i), 1'b0);
        checks++;
        if (overflow !== 1'b0)
            $display("FAIL overflow_idle: got %b, expected 0", overflow);
        else passes++;
        drive(1'b1, 8'hEE, 1'b0);
        checks++;
        if (overflow !== model_ov || overflow !== 1'b1)
            $display("FAIL overflow_set: got %b, expected 1", overflow);
        else passes++;
        overflow_clr = 1'b1;
        drive(1'b0, 8'h00, 1'b0);
        overflow_clr = 1'b0;
        checks++;
        if (overflow !== 1'b0)
            $display("FAIL overflow_clr: got %b, expected 0", overflow);
        else passes++;
        overflow_clr = 1'b1;
        drive(1'b1, 8'hEE, 1'b0);
        overflow_clr = 1'b0;
        checks++;
        if (overflow !== 1'b1)
            $display("FAIL overflow_set_wins: got %b, expected 1", overflow);
        else passes++;
        apply_reset();
        checks++;
        if (overflow !== 1'b0)
            $display("FAIL overflow_reset: got %b, expected 0", overflow);
        else passes++;
    endtask
`endif

    task automatic test_mid_reset();
        for (int i = 0; i < 5; i++) drive(1'b1, 8'(8'h30 + i), 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        drive(1'b0, 8'h00, 1'b1);
        // Assert reset between edges, where only the asynchronous path can act.
        #2;
        resetn = 1'b0;
        model_q.delete();
`ifdef UART_TX_FIFO_OVERFLOW_EN
        model_ov = 1'b0;
`endif
        #1;
        checks++;
        if (level !== 5'd0 || tx_valid !== 1'b0 || empty !== 1'b1)
            $display("FAIL mid_reset: got level=%0d tx_valid=%b empty=%b, expected 0 0 1", level, tx_valid, empty);
        else passes++;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        drive(1'b1, 8'h55, 1'b0);
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h55 || level !== 5'd1)
            $display("FAIL after_reset_push: got valid=%b data=%h level=%0d, expected 1 55 1", tx_valid, tx_data, level);
        else passes++;
        drive(1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_random();
        logic wv;
        logic tr;
        for (int i = 0; i < 600; i++) begin
            // Bias the traffic over the run so both full and empty are visited.
            wv = ($urandom_range(99) < ((i / 150) % 2 == 0 ? 75 : 30));
            tr = ($urandom_range(99) < ((i / 150) % 2 == 0 ? 30 : 75));
            drive(wv, 8'($urandom), tr);
            checks++;
            if (level !== 5'(model_q.size()) ||
                empty !== (model_q.size() == 0) ||
                full !== (model_q.size() == DEPTH) ||
                wr_ready !== (model_q.size() != DEPTH) ||
                tx_valid !== (model_q.size() != 0) ||
                (model_q.size() != 0 && tx_data !== model_q[0]))
                $display("FAIL random[%0d]: got level=%0d valid=%b data=%h full=%b, expected level=%0d head=%h",
                         i, level, tx_valid, tx_data, full, model_q.size(),
                         (model_q.size() != 0) ? model_q[0] : 8'h00);
            else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_fill_drain();
        test_back_to_back();
        test_full_push_pop();
`ifdef UART_TX_FIFO_OVERFLOW_EN
        test_overflow();
`endif
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DATA_BITS, default 8: width of each stored character.
REQ-002 Parameter DEPTH, default 16: number of entries; SHALL be a power of two, at least 2.
REQ-003 Parameter LEVEL_BITS, default $clog2(DEPTH)+1: width of the level output.
REQ-004 Port clk  input  1: sole clock; all state updates on its rising edge.
REQ-005 Port resetn  input  1: asynchronous, active-low reset.
REQ-006 Port wr_data  input  DATA_BITS: character offered by the upstream writer (bus peripheral).
REQ-007 Port wr_valid  input  1: wr_data is offered this cycle.
REQ-008 Port wr_ready  output  1: FIFO can accept a character this cycle.
REQ-009 Port tx_data  output  DATA_BITS: head-of-queue character presented to the downstream UART transmitter.
REQ-010 Port tx_valid  output  1: tx_data holds a valid character.
REQ-011 Port tx_req  input  1: transmitter ready; it takes tx_data on any edge where tx_valid && tx_req.
REQ-012 Port level  output  LEVEL_BITS: number of occupied entries, 0..DEPTH.
REQ-013 Port empty  output  1: level == 0.
REQ-014 Port full  output  1: level == DEPTH.

Function
REQ-015 Storage SHALL be a DEPTH x DATA_BITS register array with write and read pointers of $clog2(DEPTH) bits, plus a LEVEL_BITS occupancy counter.
- Pointers wrap from DEPTH-1 to 0.
REQ-016 Push SHALL occur on a rising edge where wr_valid && wr_ready.
- wr_data is written at the write pointer, and the write pointer advances by 1.
REQ-017 Pop SHALL occur on a rising edge where tx_valid && tx_req; the read pointer advances by 1.
REQ-018 wr_ready SHALL equal !full, tx_valid SHALL equal !empty, and tx_data SHALL equal the array entry at the read pointer, all driven from registered state only.
REQ-019 Latency: a character pushed into an empty FIFO SHALL appear on tx_data/tx_valid the cycle after the push edge; there is no same-cycle fall-through.
REQ-020 Level update per edge:
- push only: +1
- pop only: -1
- push and pop together: unchanged
- neither: unchanged
REQ-021 When full, wr_valid SHALL be ignored even if a pop occurs on the same edge; the freed slot becomes writable the following cycle.
REQ-022 When empty, tx_req SHALL have no effect; level never underflows and the read pointer never moves.
REQ-023 Characters SHALL leave in exactly the order accepted, with no loss or duplication, across any number of pointer wrap-arounds.
REQ-024 tx_data SHALL remain stable while tx_valid is high and no pop occurs.

Reset
REQ-025 While resetn is low, asynchronously: pointers = 0, level = 0, empty = 1, full = 0, wr_ready = 1, tx_valid = 0.
REQ-026 Reset SHALL clear pointers and level only; array contents are don't-care and are never presented, because tx_valid = 0.
REQ-027 Reset asserted mid-operation SHALL discard all queued characters; the first push after release becomes the next tx_data.

Configuration
REQ-028 Macro UART_TX_FIFO_OVERFLOW_EN.
REQ-029 When UART_TX_FIFO_OVERFLOW_EN is defined, the block SHALL add these ports:
- overflow  output  1: sticky overflow flag, reset 0.
- overflow_clr  input  1: clears the flag.
REQ-030 When UART_TX_FIFO_OVERFLOW_EN is defined, overflow SHALL behave as follows:
- set on any edge with wr_valid && full;
- cleared on an edge with overflow_clr;
- set wins when both occur on the same edge.
REQ-031 When UART_TX_FIFO_OVERFLOW_EN is undefined, neither port exists and the dropped-write behaviour of REQ-021 is unchanged.

Verification
REQ-032 Reset, then push 0x41 with tx_req = 0 -> next cycle tx_valid = 1, tx_data = 0x41, level = 1, empty = 0.
REQ-033 Push 16 values 0x00..0x0F with tx_req = 0 -> full = 1, wr_ready = 0, level = 16; a 17th write 0xFF is dropped; draining yields 0x00..0x0F in order.
REQ-034 Hold level at 8, then push and pop on the same edge for 40 cycles -> level stays 8, pointers wrap, output sequence is exactly the input sequence.
REQ-035 Full FIFO, wr_valid = 1 and tx_req = 1 on the same edge -> pop occurs, write is dropped, level = 15; next cycle wr_ready = 1.
REQ-036 With UART_TX_FIFO_OVERFLOW_EN defined: write while full -> overflow = 1; pulse overflow_clr -> 0; overflow_clr coincident with a full write -> stays 1.
REQ-037 Queue 5 characters, then assert resetn low mid-drain -> level = 0 and tx_valid = 0 immediately; after release, push 0x55 -> tx_data = 0x55.
